// File: rtl/aes_result_checker.sv
// Order- and latency-aware checker for the AES FIFO path.
// Queues plaintext on write, compares decrypted words after RD_LAT.
module aes_result_checker #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     we,
  input  logic [DATA_W-1:0]        data,
  input  logic                     re,
  input  logic [DATA_W-1:0]        decrypt_data,
  output logic                     result_valid,
  output logic                     result_match,
  output logic [DATA_W-1:0]        result_exp,
  output logic [DATA_W-1:0]        result_got,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [CNT_W-1:0]         mismatch_cnt,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow_err,
  output logic                     underflow_err,
  output logic                     idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic [RD_LAT-1:0] pv;
  logic [DATA_W-1:0] pe [RD_LAT];

  logic pop;
  logic push;
  logic ov_hit;
  logic uf_hit;
  logic res_hit;
  logic res_eq;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign idle    = empty & ~|pv;

  // A full queue can still accept a word when a pop frees a slot.
  assign pop     = re & ~empty;
  assign push    = we & (~full | pop);
  assign ov_hit  = we & full & ~re;
  assign uf_hit  = re & empty;
  assign res_hit = pv[RD_LAT-1];
  assign res_eq  = (pe[RD_LAT-1] == decrypt_data);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) pe[i] <= '0;
    end else begin
      pv[0] <= pop;
      pe[0] <= mem[rd_ptr];
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_valid <= 1'b0;
      result_match <= 1'b0;
      result_exp   <= '0;
      result_got   <= '0;
    end else begin
      result_valid <= res_hit;
      if (res_hit) begin
        result_match <= res_eq;
        result_exp   <= pe[RD_LAT-1];
        result_got   <= decrypt_data;
      end
    end
  end

  // Clear takes priority over a coinciding result or error event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt     <= '0;
      mismatch_cnt  <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (clr) begin
      match_cnt     <= '0;
      mismatch_cnt  <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (res_hit && res_eq && match_cnt != '1)
        match_cnt <= match_cnt + 1'b1;
      if (res_hit && !res_eq && mismatch_cnt != '1)
        mismatch_cnt <= mismatch_cnt + 1'b1;
      if (ov_hit) overflow_err  <= 1'b1;
      if (uf_hit) underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_result_checker.sv
// Bench for aes_result_checker: queue/pipe reference model,
// directed table, corner sequences and random traffic.
module tb_aes_result_checker;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int LAT   = 3;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          we  = 1'b0;
  logic [DW-1:0] data = '0;
  logic          re  = 1'b0;
  logic [DW-1:0] decrypt_data = '0;
  logic          result_valid;
  logic          result_match;
  logic [DW-1:0] result_exp;
  logic [DW-1:0] result_got;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] mismatch_cnt;
  logic [4:0]    level;
  logic          full;
  logic          empty;
  logic          overflow_err;
  logic          underflow_err;
  logic          idle;

  aes_result_checker #(
    .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(LAT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .data(data),
    .re(re), .decrypt_data(decrypt_data),
    .result_valid(result_valid), .result_match(result_match),
    .result_exp(result_exp), .result_got(result_got),
    .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
    .level(level), .full(full), .empty(empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .idle(idle)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plain queues with due times.
  typedef struct {
    int            due;
    logic [DW-1:0] w;
  } pend_t;

  logic [DW-1:0] mq[$];
  pend_t         pq[$];
  int            cyc = 0;
  logic          m_valid, m_match, m_ov, m_uf;
  logic [DW-1:0] m_exp, m_got;
  int            m_mc, m_mm;

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic void chk(string n, logic [DW-1:0] g,
                              logic [DW-1:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, g, e, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    pq.delete();
    m_valid = 0; m_match = 0; m_exp = '0; m_got = '0;
    m_mc = 0; m_mm = 0; m_ov = 0; m_uf = 0;
  endfunction

  function automatic void model_edge(logic w, logic [DW-1:0] d,
                                     logic r, logic c,
                                     logic [DW-1:0] dd);
    int    pre;
    pend_t p;
    cyc++;
    m_valid = 0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      p = pq.pop_front();
      m_valid = 1;
      m_exp = p.w;
      m_got = dd;
      m_match = (p.w == dd);
      if (!c) begin
        if (m_match && m_mc < CMAX) m_mc++;
        if (!m_match && m_mm < CMAX) m_mm++;
      end
    end
    pre = mq.size();
    if (r) begin
      if (pre == 0) begin
        if (!c) m_uf = 1;
      end else begin
        p.due = cyc + LAT;
        p.w = mq.pop_front();
        pq.push_back(p);
      end
    end
    if (w) begin
      if (pre < DEPTH || r) mq.push_back(d);
      else if (!c) m_ov = 1;
    end
    if (c) begin
      m_mc = 0; m_mm = 0; m_ov = 0; m_uf = 0;
    end
  endfunction

  task automatic check_all();
    chk("result_valid", DW'(result_valid), DW'(m_valid));
    chk("result_match", DW'(result_match), DW'(m_match));
    chk("result_exp", result_exp, m_exp);
    chk("result_got", result_got, m_got);
    chk("match_cnt", DW'(match_cnt), DW'(m_mc));
    chk("mismatch_cnt", DW'(mismatch_cnt), DW'(m_mm));
    chk("level", DW'(level), DW'(mq.size()));
    chk("full", DW'(full), DW'(mq.size() == DEPTH));
    chk("empty", DW'(empty), DW'(mq.size() == 0));
    chk("overflow_err", DW'(overflow_err), DW'(m_ov));
    chk("underflow_err", DW'(underflow_err), DW'(m_uf));
    chk("idle", DW'(idle),
        DW'(mq.size() == 0 && pq.size() == 0));
  endtask

  // One clock: drive inputs, let the model take the edge, compare.
  // Without a forced value, decrypt_data echoes the word under test.
  task automatic step(logic w, logic [DW-1:0] d, logic r, logic c,
                      logic force_dd, logic [DW-1:0] ddv);
    logic [DW-1:0] dd;
    dd = rnd64();
    if (force_dd) dd = ddv;
    else if (pq.size() > 0 && pq[0].due == cyc + 1) dd = pq[0].w;
    we = w; data = d; re = r; clr = c; decrypt_data = dd;
    @(posedge clk);
    model_edge(w, d, r, c, dd);
    #1;
    check_all();
  endtask

  task automatic idle_step();
    step(0, '0, 0, 0, 0, '0);
  endtask

  task automatic do_reset();
    rst = 1; we = 0; re = 0; clr = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  typedef struct {
    logic          we;
    logic          re;
    logic          clr;
    logic [DW-1:0] d;
    logic          ddf;
    logic [DW-1:0] dd;
    logic          ev;
    logic          em;
    int            el;
    logic          euf;
  } vec_t;

  vec_t tbl[8];

  localparam logic [DW-1:0] PA = 64'h0123456789ABCDEF;
  localparam logic [DW-1:0] PC = 64'h0123456789ABCDEE;
  localparam logic [DW-1:0] PB = 64'hCAFEF00D12345678;

  initial begin
    int n;
    logic [6:0] vpat;

    model_reset();
    do_reset();

    // Ten pushes, quiet gap, ten reads with faithful AES output.
    for (int i = 0; i < 10; i++) step(1, rnd64(), 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) idle_step();
    n = 0;
    for (int i = 0; i < 10 + LAT; i++) begin
      step(0, '0, i < 10, 0, 0, '0);
      if (result_valid) n++;
    end
    chk("t1_pulses", DW'(n), 64'd10);
    chk("t1_match_cnt", DW'(match_cnt), 64'd10);
    chk("t1_mismatch_cnt", DW'(mismatch_cnt), 64'd0);
    chk("t1_idle", DW'(idle), 64'd1);

    // Corrupted read followed by a read on empty with a push.
    step(0, '0, 0, 1, 0, '0);
    tbl[0] = '{1, 0, 0, PA, 0, '0, 0, 0, 1, 0};
    tbl[1] = '{0, 1, 0, '0, 0, '0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 0, '0, 0, '0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 0, '0, 0, '0, 0, 0, 0, 0};
    tbl[4] = '{0, 0, 0, '0, 1, PC, 1, 0, 0, 0};
    tbl[5] = '{1, 1, 0, PB, 0, '0, 0, 0, 1, 1};
    tbl[6] = '{0, 0, 0, '0, 0, '0, 0, 0, 1, 1};
    tbl[7] = '{0, 0, 1, '0, 0, '0, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].we, tbl[i].d, tbl[i].re, tbl[i].clr,
           tbl[i].ddf, tbl[i].dd);
      chk($sformatf("tbl%0d_valid", i), DW'(result_valid),
          DW'(tbl[i].ev));
      if (tbl[i].ev)
        chk($sformatf("tbl%0d_match", i), DW'(result_match),
            DW'(tbl[i].em));
      chk($sformatf("tbl%0d_level", i), DW'(level), DW'(tbl[i].el));
      chk($sformatf("tbl%0d_uf", i), DW'(underflow_err),
          DW'(tbl[i].euf));
      if (i == 4) begin
        chk("mm_exp", result_exp, PA);
        chk("mm_got", result_got, PC);
        chk("mm_cnt", DW'(mismatch_cnt), 64'd1);
      end
    end
    step(0, '0, 1, 0, 0, '0);
    for (int i = 0; i < LAT; i++) idle_step();

    // Overflow on the 17th push, then push+pop while full.
    step(0, '0, 0, 1, 0, '0);
    for (int i = 0; i < 16; i++) step(1, rnd64(), 0, 0, 0, '0);
    chk("ov_full16", DW'(full), 64'd1);
    chk("ov_level16", DW'(level), 64'd16);
    chk("ov_noerr16", DW'(overflow_err), 64'd0);
    step(1, rnd64(), 0, 0, 0, '0);
    chk("ov_err", DW'(overflow_err), 64'd1);
    chk("ov_level17", DW'(level), 64'd16);
    step(0, '0, 0, 1, 0, '0);
    step(1, rnd64(), 1, 0, 0, '0);
    chk("wr_full_level", DW'(level), 64'd16);
    chk("wr_full_noerr", DW'(overflow_err), 64'd0);
    for (int i = 0; i < 16 + LAT; i++) step(0, '0, i < 16, 0, 0, '0);
    chk("ov_drain_mm", DW'(mismatch_cnt), 64'd0);
    chk("ov_drain_mc", DW'(match_cnt), 64'(CMAX));
    chk("ov_drain_idle", DW'(idle), 64'd1);

    // Saturation, then clear landing on a result edge.
    step(0, '0, 0, 1, 0, '0);
    step(1, rnd64(), 0, 0, 0, '0);
    for (int i = 0; i < 20; i++) step(1, rnd64(), 1, 0, 0, '0);
    step(0, '0, 1, 0, 0, '0);
    for (int i = 0; i < LAT; i++) idle_step();
    chk("sat_mc", DW'(match_cnt), 64'(CMAX));
    step(1, rnd64(), 0, 0, 0, '0);
    step(0, '0, 1, 0, 0, '0);
    for (int i = 0; i < LAT - 1; i++) idle_step();
    step(0, '0, 0, 1, 0, '0);
    chk("clr_res_valid", DW'(result_valid), 64'd1);
    chk("clr_res_mc", DW'(match_cnt), 64'd0);

    // Four back-to-back reads: pulses on consecutive cycles.
    for (int i = 0; i < 4; i++) step(1, rnd64(), 0, 0, 0, '0);
    for (int i = 0; i < 7; i++) begin
      step(0, '0, i < 4, 0, 0, '0);
      vpat[i] = result_valid;
    end
    chk("b2b_pattern", DW'(vpat), 64'h78);

    // Same again, reset while the second result is showing.
    for (int i = 0; i < 4; i++) step(1, rnd64(), 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(0, '0, i < 4, 0, 0, '0);
    chk("rst_pre_valid", DW'(result_valid), 64'd1);
    rst = 1; we = 0; re = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      idle_step();
      if (result_valid) n++;
    end
    chk("rst_no_pulses", DW'(n), 64'd0);
    chk("rst_cnt", DW'(match_cnt), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1) == 1, rnd64(),
           $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0,
           $urandom_range(0, 3) == 0, rnd64());
    for (int i = 0; i < LAT + 1; i++) idle_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_result_checker.md
Name: aes_result_checker

Overview:
- Downstream checking stage for the 64-bit AES encrypt/decrypt FIFO block.
- Taps the same `we`/`data` write strobe that feeds the AES block and queues each plaintext as an expected word.
- Taps the `re` read strobe and `decrypt_data`, and compares each decrypted word against the oldest queued plaintext after a fixed read latency.
- Reports per-word results and running pass/fail counters. Replaces the combinational scoreboard with an order-aware, latency-aware sequential checker.

Parameters:
- DATA_W, 64, width of plaintext/decrypted word
- DEPTH, 16, expected-queue entries (power of 2, >=2)
- RD_LAT, 1, cycles from `re` sampled high to `decrypt_data` valid (1..4)
- CNT_W, 16, width of match/mismatch counters

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of counters and sticky errors; queue untouched
- we  in  1  AES write strobe; push `data` as expected word
- data  in  DATA_W  plaintext presented to AES
- re  in  1  AES read strobe; schedules one compare
- decrypt_data  in  DATA_W  AES decrypted output
- result_valid  out  1  one-cycle pulse per completed compare
- result_match  out  1  valid with `result_valid`; 1 = equal
- result_exp  out  DATA_W  expected word of last compare
- result_got  out  DATA_W  decrypted word of last compare
- match_cnt  out  CNT_W  saturating count of matches
- mismatch_cnt  out  CNT_W  saturating count of mismatches
- level  out  $clog2(DEPTH)+1  entries in expected queue
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- overflow_err  out  1  sticky: `we` while full without `re`
- underflow_err  out  1  sticky: `re` while empty
- idle  out  1  empty and no compare in flight

Behaviour:
- Reset (async, rst=1): pointers, level, counters, and the latency pipe are cleared. `result_*`=0, both error flags=0, `empty`=1, `idle`=1, `full`=0. Reset mid-compare discards in-flight compares; no `result_valid` is produced for them.
- Expected queue: circular buffer, wr_ptr/rd_ptr wrap modulo DEPTH, level tracked explicitly.
- Push:
  - `we`=1 and not full: store `data` at wr_ptr; wr_ptr+1.
  - `we`=1 and full and `re`=0: word dropped; overflow_err set.
- Pop:
  - `re`=1 and not empty: read entry at rd_ptr into latency pipe stage 0 with valid=1; rd_ptr+1.
  - `re`=1 and empty: underflow_err set; no compare scheduled. This holds even if `we`=1 in the same cycle; there is no write-through.
- Simultaneous `we` and `re`:
  - Full: pop and push both occur; level unchanged, no overflow.
  - Neither empty nor full: both occur; level unchanged.
- Latency pipe:
  - RD_LAT stages of {valid, expected}.
  - The entry popped at edge E reaches the last stage so that `decrypt_data` is sampled at edge E+RD_LAT.
  - At that edge, register `result_valid`=1, `result_exp`, `result_got`=`decrypt_data`, and `result_match`=(exp==got).
  - `result_valid` is high for exactly one cycle. `result_exp`/`result_got`/`result_match` hold until the next compare.
  - Back-to-back `re` on consecutive cycles yields back-to-back results, in order.
- Counters: at each result edge, increment `match_cnt` or `mismatch_cnt`; saturate at 2^CNT_W-1, never wrap.
- `clr`=1: zero both counters and both sticky errors on the next edge. If a result lands on the same edge, `clr` wins and that result is not counted, though the `result_*` outputs still update.
- `idle` = empty AND no valid bit in the latency pipe.
- All outputs are registered; no combinational path from inputs to outputs except `full`/`empty`/`idle`/`level`, which are decoded from registered state.

Test Plan:
- Reset then 10 random pushes (seeded), 5 idle cycles, 10 reads with AES model returning plaintext → 10 `result_valid` pulses in push order, `match_cnt`=10, `mismatch_cnt`=0, `idle`=1 at end.
- Push 0x0123456789ABCDEF; corrupt `decrypt_data` to 0x0123456789ABCDEE; read → `result_match`=0, `result_exp`=0x0123456789ABCDEF, `result_got`=0x0123456789ABCDEE, `mismatch_cnt`=1.
- 17 pushes with DEPTH=16 → `full`=1 after 16, `overflow_err`=1, `level`=16; then `we`+`re` together while full → `level` stays 16, no new error; 16 reads → 16 matches, 17th word never compared.
- `re` on empty queue, with `we`=1 same cycle → `underflow_err`=1, no `result_valid`, `level`=1 afterwards.
- RD_LAT=3, 4 consecutive `re` cycles → `result_valid` high exactly on 4 consecutive cycles starting 3 edges after first `re`; assert rst during 2nd result → all results cleared, counters 0, no further pulses.
- CNT_W=4: 20 matching compares → `match_cnt` saturates at 15; `clr` coincident with a result → counters 0 after edge.
